// File: rtl/z80_bus_target_pkg.sv
// z80_bus_target_pkg: shared FSM state and bus-cycle type encodings
package z80_bus_target_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_DONE} state_t;
  typedef enum logic [1:0] {C_NONE, C_MEM, C_IO, C_INTA} cyc_t;
endpackage

// File: rtl/z80_bus_target_wait_gen.sv
// z80_bus_target_wait_gen: loadable 4-bit down-counter producing wait_n and a done flag
module z80_bus_target_wait_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_count,
  output logic       o_wait_n,
  output logic       o_done
);
  logic [3:0] r_cnt;
  logic       r_wait_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt    <= '0;
      r_wait_n <= 1'b1;
    end else if (i_load) begin
      r_cnt    <= i_count;
      r_wait_n <= i_count == 4'd0;
    end else if (r_cnt != 4'd0) begin
      r_cnt    <= r_cnt - 4'd1;
      r_wait_n <= r_cnt == 4'd1;
    end
  assign o_wait_n = r_wait_n;
  assign o_done   = r_cnt == 4'd1;
endmodule

// File: rtl/z80_bus_target.sv
// z80_bus_target: Z80 memory/IO bus slave with wait states, internal RAM, I/O window and INTA
module z80_bus_target
  import z80_bus_target_pkg::*;
#(
  parameter int          AW       = 14,
  parameter logic [15:0] MEM_BASE = 16'h0,
  parameter logic [7:0]  IO_BASE  = 8'hB0,
  parameter int          WAIT_MEM = 0,
  parameter int          WAIT_IO  = 1,
  parameter logic [7:0]  INT_VEC  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  output logic        int_n,
  input  logic        irq,
  output logic        int_ack,
  output logic        io_wr,
  output logic [1:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata
);
  localparam logic [3:0] WM = 4'(WAIT_MEM);
  localparam logic [3:0] WI = 4'(WAIT_IO);
  state_t     r_state, w_next;
  cyc_t       r_cyc;
  logic [7:0] r_ram [2**AW];
  logic [7:0] r_rdata, r_io_wdata;
  logic [1:0] r_io_addr;
  logic       r_pend, r_int_n, r_int_ack, r_io_wr;
  logic       w_idle, w_mem, w_io, w_inta, w_load, w_wait_done, w_commit, w_drive;
  logic [3:0] w_cnt;
  assign w_idle   = r_state == S_IDLE;
  assign w_mem    = w_idle && !mreq_n && rfsh_n && a[15:AW] == MEM_BASE[15:AW];
  assign w_io     = w_idle && !iorq_n && m1_n && a[7:2] == IO_BASE[7:2];
  assign w_inta   = w_idle && !iorq_n && !m1_n;
  assign w_load   = w_mem || w_io;
  assign w_cnt    = w_mem ? WM : WI;
  assign w_commit = r_state == S_ACTIVE && !wr_n && r_cyc != C_INTA;
  z80_bus_target_wait_gen u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_count (w_cnt),
    .o_wait_n(wait_n),
    .o_done  (w_wait_done)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_load ? (w_cnt != 4'd0 ? S_WAIT : S_ACTIVE) : w_inta ? S_ACTIVE : S_IDLE;
      S_WAIT:   w_next = w_wait_done ? S_ACTIVE : S_WAIT;
      S_ACTIVE: w_next = (!wr_n || !rd_n || r_cyc == C_INTA || (mreq_n && iorq_n)) ? S_DONE : S_ACTIVE;
      default:  w_next = (mreq_n && iorq_n) ? S_IDLE : S_DONE;
    endcase
  end
  // Drive only while the owning strobe is still low so release is combinational; never during a write
  assign w_drive = !w_idle && wr_n &&
                   (r_cyc == C_INTA ? (!iorq_n && !m1_n) : (!rd_n && (r_cyc == C_MEM ? !mreq_n : !iorq_n)));
  assign d = w_drive ? (r_cyc == C_INTA ? INT_VEC : r_rdata) : 8'hzz;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cyc      <= C_NONE;
      r_rdata    <= '0;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
      r_io_wr    <= 1'b0;
      r_int_ack  <= 1'b0;
      r_pend     <= 1'b0;
      r_int_n    <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_load || w_inta) r_cyc <= w_mem ? C_MEM : w_io ? C_IO : C_INTA;
      if (w_load) r_rdata <= w_io ? io_rdata : r_ram[a[AW-1:0]];
      if (w_io) r_io_addr <= a[1:0];
      if (w_commit && r_cyc == C_IO) r_io_wdata <= d;
      r_io_wr   <= w_commit && r_cyc == C_IO;
      r_int_ack <= w_inta;
      r_pend    <= irq || (r_pend && !w_inta);
      r_int_n   <= w_inta || !r_pend;
    end
  always_ff @(posedge clk)
    if (w_commit && r_cyc == C_MEM) r_ram[a[AW-1:0]] <= d;
  assign io_wr    = r_io_wr;
  assign io_addr  = r_io_addr;
  assign io_wdata = r_io_wdata;
  assign int_ack  = r_int_ack;
  assign int_n    = r_int_n;
endmodule

// File: tb/tb_z80_bus_target.sv
// tb_z80_bus_target: directed bus-cycle tests for z80_bus_target (3-wait and 0-wait instances)
module tb_z80_bus_target;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] a = '0;
  wire  [7:0]  d;
  logic        mreq_n = 1'b1, mreq0_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        m1_n = 1'b1, rfsh_n = 1'b1, irq = 1'b0, drv = 1'b0;
  logic [7:0]  dval = '0, io_rdata = '0, rel, rdv;
  logic        wait_n, int_n, int_ack, io_wr, wait0_n, int0_n, int_ack0, io_wr0;
  logic [1:0]  io_addr, io_addr0;
  logic [7:0]  io_wdata, io_wdata0;
  int          vecs = 0, errs = 0, io_wr_cnt = 0, wait0_lows = 0, nw;

  always #5 clk = ~clk;
  assign d = drv ? dval : 8'hzz;
  // undriven bus reads as 00h
  for (genvar i = 0; i < 8; i++) begin : g_pd
    pulldown (d[i]);
  end

  z80_bus_target #(.MEM_BASE(16'h8000), .WAIT_MEM(3), .WAIT_IO(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .d(d), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n), .wait_n(wait_n), .int_n(int_n), .irq(irq),
    .int_ack(int_ack), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata));

  z80_bus_target #(.MEM_BASE(16'h8000), .WAIT_MEM(0), .WAIT_IO(1)) u_zw (
    .clk(clk), .rst_n(rst_n), .a(a), .d(d), .mreq_n(mreq0_n), .iorq_n(1'b1), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .rfsh_n(rfsh_n), .wait_n(wait0_n), .int_n(int0_n), .irq(1'b0),
    .int_ack(int_ack0), .io_wr(io_wr0), .io_addr(io_addr0), .io_wdata(io_wdata0), .io_rdata(8'h00));

  always @(negedge clk) begin
    if (io_wr) io_wr_cnt++;
    if (wait0_n === 1'b0) wait0_lows++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  // kind 0: RAM on 3-wait instance, 1: RAM on 0-wait instance, 2: I/O on 3-wait instance
  task automatic bus(input int kind, input logic [15:0] addr, input logic wr, input logic [7:0] wd,
                     output logic [7:0] rd, output int waits);
    @(negedge clk);
    a = addr;
    if (kind == 0) mreq_n = 1'b0; else if (kind == 1) mreq0_n = 1'b0; else iorq_n = 1'b0;
    if (wr) begin drv = 1'b1; dval = wd; end else rd_n = 1'b0;
    waits = 0;
    @(negedge clk);
    if (wr) wr_n = 1'b0;
    while ((kind == 1 ? wait0_n : wait_n) === 1'b0 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 rd = d;
    @(negedge clk);
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; mreq0_n = 1'b1; iorq_n = 1'b1; drv = 1'b0;
    #1 rel = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    vecs++; if (wait_n !== 1'b1) begin errs++; $display("FAIL reset_wait_n: got %b want 1", wait_n); end
    vecs++; if (int_n !== 1'b1) begin errs++; $display("FAIL reset_int_n: got %b want 1", int_n); end
    vecs++; if (int_ack !== 1'b0) begin errs++; $display("FAIL reset_int_ack: got %b want 0", int_ack); end
    vecs++; if (io_wr !== 1'b0) begin errs++; $display("FAIL reset_io_wr: got %b want 0", io_wr); end
    vecs++; if (io_addr !== 2'd0) begin errs++; $display("FAIL reset_io_addr: got %h want 0", io_addr); end
    vecs++; if (io_wdata !== 8'h00) begin errs++; $display("FAIL reset_io_wdata: got %h want 00", io_wdata); end
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL reset_d: got %h want released 00", d); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    bus(1, 16'h8000, 1'b1, 8'h5A, rdv, nw);
    vecs++; if (nw !== 0) begin errs++; $display("FAIL zw_write_waits: got %0d want 0", nw); end
    bus(1, 16'h8000, 1'b0, 8'h00, rdv, nw);
    vecs++; if (rdv !== 8'h5A) begin errs++; $display("FAIL zw_read_data: got %h want 5a", rdv); end
    vecs++; if (nw !== 0) begin errs++; $display("FAIL zw_read_waits: got %0d want 0", nw); end
    vecs++; if (rel !== 8'h00) begin errs++; $display("FAIL zw_read_release: got %h want 00", rel); end
    vecs++; if (wait0_lows !== 0) begin errs++; $display("FAIL zw_wait_never_low: got %0d low clks want 0", wait0_lows); end
  endtask

  task automatic test_mem_wait();
    bus(0, 16'h8001, 1'b1, 8'h3C, rdv, nw);
    vecs++; if (nw !== 3) begin errs++; $display("FAIL mw_write_waits: got %0d want 3", nw); end
    bus(0, 16'h8002, 1'b1, 8'hA5, rdv, nw);
    bus(0, 16'h8001, 1'b0, 8'h00, rdv, nw);
    vecs++; if (rdv !== 8'h3C) begin errs++; $display("FAIL mw_read_8001: got %h want 3c", rdv); end
    vecs++; if (nw !== 3) begin errs++; $display("FAIL mw_read_waits: got %0d want 3", nw); end
    bus(0, 16'h8002, 1'b0, 8'h00, rdv, nw);
    vecs++; if (rdv !== 8'hA5) begin errs++; $display("FAIL mw_read_8002: got %h want a5", rdv); end
    bus(0, 16'h4001, 1'b0, 8'h00, rdv, nw);
    vecs++; if (rdv !== 8'h00 || nw !== 0) begin errs++; $display("FAIL mw_out_of_window: got d=%h waits=%0d want 00/0", rdv, nw); end
  endtask

  task automatic test_io();
    int c0;
    c0 = io_wr_cnt;
    bus(2, 16'h00B2, 1'b1, 8'h77, rdv, nw);
    vecs++; if (io_wr_cnt - c0 !== 1) begin errs++; $display("FAIL io_wr_pulses: got %0d want 1", io_wr_cnt - c0); end
    vecs++; if (io_addr !== 2'd2) begin errs++; $display("FAIL io_wr_addr: got %0d want 2", io_addr); end
    vecs++; if (io_wdata !== 8'h77) begin errs++; $display("FAIL io_wr_data: got %h want 77", io_wdata); end
    vecs++; if (nw !== 1) begin errs++; $display("FAIL io_wr_waits: got %0d want 1", nw); end
    io_rdata = 8'hC3;
    bus(2, 16'h00B1, 1'b0, 8'h00, rdv, nw);
    vecs++; if (rdv !== 8'hC3) begin errs++; $display("FAIL io_rd_data: got %h want c3", rdv); end
    vecs++; if (io_addr !== 2'd1) begin errs++; $display("FAIL io_rd_addr: got %0d want 1", io_addr); end
    bus(2, 16'h00B5, 1'b0, 8'h00, rdv, nw);
    vecs++; if (rdv !== 8'h00 || nw !== 0) begin errs++; $display("FAIL io_out_of_window: got d=%h waits=%0d want 00/0", rdv, nw); end
  endtask

  task automatic test_irq();
    @(negedge clk) irq = 1'b1;
    @(negedge clk) irq = 1'b0;
    vecs++; if (int_n !== 1'b1) begin errs++; $display("FAIL irq_int_n_not_yet: got %b want 1", int_n); end
    @(negedge clk);
    vecs++; if (int_n !== 1'b0) begin errs++; $display("FAIL irq_int_n_low: got %b want 0", int_n); end
    irq = 1'b1;
    @(negedge clk) irq = 1'b0;
    @(negedge clk) begin m1_n = 1'b0; iorq_n = 1'b0; irq = 1'b1; end
    @(posedge clk) #1;
    vecs++; if (int_ack !== 1'b1) begin errs++; $display("FAIL inta_ack_pulse: got %b want 1", int_ack); end
    vecs++; if (int_n !== 1'b1) begin errs++; $display("FAIL inta_int_n_high: got %b want 1", int_n); end
    vecs++; if (d !== 8'hFF) begin errs++; $display("FAIL inta_vector: got %h want ff", d); end
    @(negedge clk) irq = 1'b0;
    @(posedge clk) #1;
    vecs++; if (int_ack !== 1'b0) begin errs++; $display("FAIL inta_ack_one_clk: got %b want 0", int_ack); end
    vecs++; if (int_n !== 1'b0) begin errs++; $display("FAIL inta_reassert: got %b want 0", int_n); end
    @(negedge clk) begin iorq_n = 1'b1; m1_n = 1'b1; end
    #1;
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL inta_release: got %h want 00", d); end
    @(negedge clk) begin m1_n = 1'b0; iorq_n = 1'b0; end
    @(negedge clk) begin iorq_n = 1'b1; m1_n = 1'b1; end
    @(negedge clk); @(negedge clk);
    vecs++; if (int_n !== 1'b1) begin errs++; $display("FAIL inta_cleared: got %b want 1", int_n); end
  endtask

  task automatic test_refresh();
    int lows;
    lows = 0;
    @(negedge clk) begin a = 16'h8001; mreq_n = 1'b0; rfsh_n = 1'b0; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wait_n !== 1'b1) lows++;
    end
    vecs++; if (lows !== 0) begin errs++; $display("FAIL rfsh_wait: got %0d low clks want 0", lows); end
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL rfsh_d: got %h want 00", d); end
    mreq_n = 1'b1; rfsh_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk) begin a = 16'h8001; mreq_n = 1'b0; rd_n = 1'b0; end
    @(negedge clk);
    vecs++; if (wait_n !== 1'b0 || d !== 8'h3C) begin errs++; $display("FAIL rst_pre: got wait_n=%b d=%h want 0/3c", wait_n, d); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (wait_n !== 1'b1) begin errs++; $display("FAIL rst_wait_n: got %b want 1", wait_n); end
    vecs++; if (d !== 8'h00) begin errs++; $display("FAIL rst_d_release: got %h want 00", d); end
    @(negedge clk) begin mreq_n = 1'b1; rd_n = 1'b1; rst_n = 1'b1; end
    @(negedge clk) begin a = 16'h8001; mreq_n = 1'b0; drv = 1'b1; dval = 8'h99; end
    @(negedge clk) wr_n = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) begin wr_n = 1'b1; mreq_n = 1'b1; drv = 1'b0; end
    @(negedge clk) rst_n = 1'b1;
    bus(0, 16'h8001, 1'b0, 8'h00, rdv, nw);
    vecs++; if (rdv !== 8'h3C) begin errs++; $display("FAIL rst_no_commit: got %h want 3c", rdv); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_mem_wait();
    test_io();
    test_irq();
    test_refresh();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
